ms_alarm_scheduler: RTL and testbench
=====================================

Name: ms_alarm_scheduler

Overview:
- Shares one millisecond time base among NUM_CH requesters, such as game-logic FSMs that need "wake me in K ms" delays.
- Owns the clock prescaler that generates the ms pulse.
- Accepts delay loads through a round-robin-arbitrated req/ack handshake, one load per cycle.
- Keeps one countdown per channel and pulses expire[ch] when that channel's delay elapses.

Parameters:
NUM_CH, 4, number of requester channels (2..8)
CNT_W, 16, width of each delay value in ms
TICK_DIV, 50000, clk cycles per ms pulse (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  NUM_CH  per-channel load request, level
dly  in  NUM_CH*CNT_W  per-channel delay in ms; channel i uses bits [i*CNT_W +: CNT_W]
cancel  in  NUM_CH  per-channel abort, sampled each cycle
ack  out  NUM_CH  one-cycle grant pulse, registered
busy  out  NUM_CH  channel is counting down
expire  out  NUM_CH  one-cycle pulse when the delay has elapsed
ms_pulse  out  1  one-cycle pulse every TICK_DIV clocks

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high. While rst=1 at a rising edge:
  - ack, busy, expire and ms_pulse go to 0.
  - Prescaler, round-robin pointer and all countdowns clear.
  - A reset during a countdown discards it with no expire.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - ms_pulse is registered and asserted for the one cycle after the prescaler equals TICK_DIV-1, so the period is exactly TICK_DIV.
- Arbitration (each cycle):
  - Eligible set = req & ~busy & ~cancel.
  - Search starts at the pointer and wraps upward; the first eligible channel g is granted.
  - On a grant, the pointer becomes (g+1) mod NUM_CH; with no grant, the pointer holds.
  - At most one grant per cycle.
- Grant of channel g at edge E:
  - ack[g]=1 for the cycle after E.
  - The countdown loads dly[g]; busy[g]=1 from the cycle after E.
  - If dly[g]==0, busy stays 0 and expire[g] and ack[g] pulse in the same cycle.
- Requester handshake:
  - Must drop req in the cycle it sees ack.
  - A held req is not regranted while busy; it is regranted after expiry or cancel, which then reads as a new load.
- Countdown:
  - On each ms_pulse cycle, every busy channel with remaining>1 decrements by 1.
  - When remaining==1 at a ms_pulse cycle, the next cycle shows busy=0 and expire=1 for one cycle.
  - A delay of D therefore expires on the D-th ms_pulse after load. Jitter versus wall time is up to one ms period, because loads are not aligned to the prescaler.
- Simultaneous events:
  - Load and ms_pulse in the same cycle: the load wins; the new value is not decremented in that cycle.
  - cancel[i] while busy[i]: busy clears next cycle and no expire is raised.
  - cancel and final decrement in the same cycle: cancel wins, no expire.
  - cancel on an idle channel: no effect.
  - cancel with req on the same channel: no grant.
- Arithmetic:
  - Countdowns are unsigned CNT_W and never decrement below 1.
  - No wrap-around is possible; the maximum delay is 2^CNT_W-1 ms.

Optional Feature:
- Macro: MS_ALARM_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit).
  - While pause=1, the prescaler holds its value, ms_pulse stays 0 and all countdowns freeze.
  - Arbitration, loads (including dly=0 immediate expire) and cancels continue to work.
  - On release, counting resumes from the frozen prescaler value, with no extra or lost pulse.
- Not defined: the port is absent and timing runs continuously.

Test Plan:
(all with TICK_DIV=4, NUM_CH=4, CNT_W=16)
1. Prescaler: reset for 2 cycles, then free-run 40 cycles -> ms_pulse high exactly once every 4 cycles, first high on the 4th cycle after reset release; ack, busy and expire all 0.
2. Single load: req[1]=1 with dly=3 until ack -> ack[1] one cycle; busy[1] high; expire[1] pulses one cycle after the 3rd following ms_pulse; busy[1] low in the same cycle.
3. Round-robin fairness: req=4'b1111 held, dly=5 each, pointer at 0 -> ack order ch0, ch1, ch2, ch3 on consecutive cycles; a repeat with pointer at 2 -> order 2, 3, 0, 1.
4. Boundary cases:
   - dly=0 on ch2 -> ack[2] and expire[2] in the same cycle, busy[2] never asserted.
   - dly=16'hFFFF -> still busy after 65534 ms pulses, expires on the 65535th.
5. Cancel races:
   - cancel[0] in the same cycle as ch0's final ms_pulse -> no expire[0], busy[0] cleared.
   - cancel[3] together with req[3] -> no ack[3] that cycle.
   - rst asserted mid-countdown -> busy and expire stay 0 afterwards.
6. With MS_ALARM_PAUSE_EN:
   - Load dly=2, assert pause for 20 cycles after the first ms_pulse -> no ms_pulse during pause; expire occurs on the 2nd pulse after release.
   - A load with dly=0 during pause still expires immediately.

Source files
------------

// File: rtl/ms_alarm_scheduler_if.sv
// Request/grant bundle between the alarm scheduler and its requesters.
// The master side (requesters) drives loads and cancels; the slave side (scheduler) answers.
interface ms_alarm_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH*CNT_W-1:0] dly;
    logic [NUM_CH-1:0]       cancel;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       expire;
    logic                    ms_pulse;

    modport master (output req, dly, cancel, input ack, busy, expire, ms_pulse);
    modport slave  (input req, dly, cancel, output ack, busy, expire, ms_pulse);
endinterface

// File: rtl/ms_alarm_scheduler.sv
// Shared ms time base with NUM_CH round-robin loaded countdown alarms.
// Optional MS_ALARM_PAUSE_EN adds a pause input that freezes the prescaler and all countdowns.
module ms_alarm_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
`ifdef MS_ALARM_PAUSE_EN
    input  logic pause,
`endif
    ms_alarm_scheduler_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PW-1:0]     presc;
    logic              ms_q;
    logic              run;
    logic [IW-1:0]     ptr;
    logic [NUM_CH-1:0] busy_v, ack_v, exp_v;
    logic [NUM_CH-1:0] elig, gnt;
    logic              gnt_vld;
    logic [IW-1:0]     gnt_idx, idx;

`ifdef MS_ALARM_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    // Prescaler holds at its current value while paused so no pulse is gained or lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            ms_q  <= 1'b0;
        end else begin
            ms_q <= run && (presc == PW'(TICK_DIV - 1));
            if (run)
                presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
        end
    end

    assign elig = bus.req & ~busy_v & ~bus.cancel;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = IW'((int'(ptr) + k) % NUM_CH);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        if (gnt_vld)
            gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (gnt_vld)
            ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] rem;
        logic [CNT_W-1:0] d;
        logic             bsy, ak, ex;

        assign d = bus.dly[i*CNT_W +: CNT_W];

        // A grant only happens on an idle channel, so it never collides with a decrement.
        always_ff @(posedge clk) begin
            if (rst) begin
                rem <= '0;
                bsy <= 1'b0;
                ak  <= 1'b0;
                ex  <= 1'b0;
            end else begin
                ak <= 1'b0;
                ex <= 1'b0;
                if (gnt[i]) begin
                    ak <= 1'b1;
                    if (d == '0) begin
                        ex <= 1'b1;
                    end else begin
                        bsy <= 1'b1;
                        rem <= d;
                    end
                end else if (bsy) begin
                    if (bus.cancel[i]) begin
                        bsy <= 1'b0;
                        rem <= '0;
                    end else if (ms_q) begin
                        if (rem == CNT_W'(1)) begin
                            bsy <= 1'b0;
                            ex  <= 1'b1;
                            rem <= '0;
                        end else begin
                            rem <= rem - 1'b1;
                        end
                    end
                end
            end
        end

        assign busy_v[i] = bsy;
        assign ack_v[i]  = ak;
        assign exp_v[i]  = ex;
    end

    assign bus.busy     = busy_v;
    assign bus.ack      = ack_v;
    assign bus.expire   = exp_v;
    assign bus.ms_pulse = ms_q;
endmodule

// File: tb/tb_ms_alarm_scheduler.sv
// Directed bench for ms_alarm_scheduler: main instance (4 ch, 16 bit, div 4) plus a
// narrow instance (2 ch, 4 bit, div 2) used to reach the all-ones delay quickly.
module tb_ms_alarm_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ms_alarm_scheduler_if #(.NUM_CH(4), .CNT_W(16)) ifm ();
    ms_alarm_scheduler_if #(.NUM_CH(2), .CNT_W(4))  ifs ();

`ifdef MS_ALARM_PAUSE_EN
    logic pause = 1'b0;
    logic pause_s = 1'b0;
`endif

    ms_alarm_scheduler #(.NUM_CH(4), .CNT_W(16), .TICK_DIV(4)) dut (
        .clk(clk), .rst(rst),
`ifdef MS_ALARM_PAUSE_EN
        .pause(pause),
`endif
        .bus(ifm.slave));

    ms_alarm_scheduler #(.NUM_CH(2), .CNT_W(4), .TICK_DIV(2)) dut_s (
        .clk(clk), .rst(rst_s),
`ifdef MS_ALARM_PAUSE_EN
        .pause(pause_s),
`endif
        .bus(ifs.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count ms pulses, including the current cycle, until n are seen; also OR up expire.
    task automatic count_pulses(input bit sel, input int n, output int got, output logic [3:0] exp_acc);
        got = 0;
        exp_acc = '0;
        for (int i = 0; i < 400; i++) begin
            if (sel ? ifs.ms_pulse : ifm.ms_pulse) got++;
            exp_acc |= sel ? {2'b00, ifs.expire} : ifm.expire;
            if (got == n) break;
            step();
        end
    endtask

    task automatic wait_ms(input string tag);
        int i;
        for (i = 0; i < 8; i++) begin
            if (ifm.ms_pulse) break;
            step();
        end
        if (i == 8) chk(tag, 32'd0, 32'd1);
    endtask

    initial begin
        logic [3:0]  acc;
        logic [3:0]  exp_rr [4];
        int          cnt;

        ifm.req = '0; ifm.dly = '0; ifm.cancel = '0;
        ifs.req = '0; ifs.dly = '0; ifs.cancel = '0;

        // Reset state and prescaler period
        step(); step();
        chk("rst_ack",  ifm.ack, 0);
        chk("rst_busy", ifm.busy, 0);
        chk("rst_exp",  ifm.expire, 0);
        chk("rst_ms",   ifm.ms_pulse, 0);
        rst = 1'b0;
        acc = '0;
        for (int k = 1; k <= 40; k++) begin
            step();
            chk($sformatf("ms_k%0d", k), ifm.ms_pulse, (k % 4 == 0) ? 1 : 0);
            acc |= ifm.ack | ifm.busy | ifm.expire;
        end
        chk("idle_outs", acc, 0);

        // Single load, dly=3 on ch1
        ifm.req = 4'b0010; ifm.dly[16 +: 16] = 16'd3;
        step();
        chk("ld_ack", ifm.ack, 4'b0010);
        chk("ld_busy", ifm.busy, 4'b0010);
        ifm.req = '0;
        step();
        chk("ld_ack_drop", ifm.ack, 0);
        count_pulses(0, 3, cnt, acc);
        chk("ld_pulses", cnt, 3);
        chk("ld_no_early_exp", acc, 0);
        chk("ld_busy_p3", ifm.busy, 4'b0010);
        step();
        chk("ld_exp", ifm.expire, 4'b0010);
        chk("ld_busy_clr", ifm.busy, 0);
        step();
        chk("ld_exp_1cyc", ifm.expire, 0);

        // Round robin from pointer 0
        rst = 1'b1; step(); rst = 1'b0;
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        ifm.req = 4'b1111;
        for (int c = 0; c < 4; c++) ifm.dly[c*16 +: 16] = 16'd5;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rr0_%0d", k), ifm.ack, exp_rr[k]);
            ifm.req &= ~ifm.ack;
        end
        chk("rr0_busy", ifm.busy, 4'b1111);
        ifm.req = '0; ifm.cancel = 4'b1111;
        step();
        chk("cxl_all_busy", ifm.busy, 0);
        chk("cxl_all_exp", ifm.expire, 0);
        ifm.cancel = '0;

        // dly=0 on ch2: immediate expire, never busy
        ifm.req = 4'b0100; ifm.dly[32 +: 16] = 16'd0;
        step();
        chk("z_ack", ifm.ack, 4'b0100);
        chk("z_exp", ifm.expire, 4'b0100);
        chk("z_busy", ifm.busy, 0);
        ifm.req = '0;
        step();
        chk("z_exp_drop", ifm.expire, 0);
        chk("z_busy2", ifm.busy, 0);

        // Grant ch1 (search from 3 wraps to 1) to leave the pointer at 2
        ifm.req = 4'b0010; ifm.dly[16 +: 16] = 16'd0;
        step();
        chk("z1_ack", ifm.ack, 4'b0010);
        ifm.req = '0;
        step();

        // Round robin from pointer 2
        exp_rr = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        ifm.req = 4'b1111;
        for (int c = 0; c < 4; c++) ifm.dly[c*16 +: 16] = 16'd5;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rr2_%0d", k), ifm.ack, exp_rr[k]);
            ifm.req &= ~ifm.ack;
        end
        ifm.req = '0; ifm.cancel = 4'b1111;
        step();
        ifm.cancel = '0;

        // Max 16-bit value loads intact and keeps counting
        ifm.req = 4'b0001; ifm.dly[0 +: 16] = 16'hFFFF;
        step();
        ifm.req = '0;
        count_pulses(0, 5, cnt, acc);
        step();
        chk("ffff_busy", ifm.busy, 4'b0001);
        chk("ffff_no_exp", acc, 0);
        ifm.cancel = 4'b0001;
        step();
        ifm.cancel = '0;

        // Cancel on the final ms pulse wins over expiry
        ifm.req = 4'b0001; ifm.dly[0 +: 16] = 16'd1;
        step();
        chk("cf_ack", ifm.ack, 4'b0001);
        ifm.req = '0;
        wait_ms("cf_wait_to");
        ifm.cancel = 4'b0001;
        step();
        chk("cf_busy", ifm.busy, 0);
        chk("cf_exp", ifm.expire, 0);
        ifm.cancel = '0;
        step();
        chk("cf_exp2", ifm.expire, 0);

        // Cancel together with req blocks the grant
        ifm.req = 4'b1000; ifm.cancel = 4'b1000; ifm.dly[48 +: 16] = 16'd5;
        step();
        chk("cr_ack", ifm.ack, 0);
        chk("cr_busy", ifm.busy, 0);
        ifm.cancel = '0;
        step();
        chk("cr_ack_late", ifm.ack, 4'b1000);
        ifm.req = '0; ifm.cancel = 4'b1000;
        step();
        chk("cr_cxl", ifm.busy, 0);
        ifm.cancel = '0;

        // Reset mid-countdown discards the alarm
        ifm.req = 4'b0010; ifm.dly[16 +: 16] = 16'd2;
        step();
        chk("rm_busy", ifm.busy, 4'b0010);
        ifm.req = '0;
        step(); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rm_busy_rst", ifm.busy, 0);
        acc = '0;
        for (int k = 0; k < 20; k++) begin
            step();
            acc |= ifm.busy | ifm.expire;
        end
        chk("rm_quiet", acc, 0);

`ifdef MS_ALARM_PAUSE_EN
        // Pause: load dly=2 right after a pulse, hold pause 20 cycles
        wait_ms("pz_wait_to");
        step();
        pause = 1'b1;
        ifm.req = 4'b0001; ifm.dly[0 +: 16] = 16'd2;
        step();
        chk("pz_ack", ifm.ack, 4'b0001);
        ifm.req = '0;
        acc = '0;
        for (int k = 0; k < 20; k++) begin
            step();
            acc[0] |= ifm.ms_pulse;
            acc[1] |= ifm.expire[0];
        end
        chk("pz_quiet", acc, 0);
        ifm.req = 4'b0010; ifm.dly[16 +: 16] = 16'd0;
        step();
        chk("pz_z_exp", ifm.expire, 4'b0010);
        ifm.req = '0;
        pause = 1'b0;
        step();
        count_pulses(0, 2, cnt, acc);
        chk("pz_pulses", cnt, 2);
        chk("pz_no_early", acc, 0);
        step();
        chk("pz_exp", ifm.expire, 4'b0001);
`endif

        // All-ones delay on the narrow instance: 15 pulses
        rst_s = 1'b0;
        step();
        ifs.req = 2'b01; ifs.dly[0 +: 4] = 4'hF;
        step();
        chk("s_ack", ifs.ack, 2'b01);
        chk("s_busy", ifs.busy, 2'b01);
        ifs.req = '0;
        count_pulses(1, 15, cnt, acc);
        chk("s_pulses", cnt, 15);
        chk("s_no_early", acc, 0);
        chk("s_busy_p15", ifs.busy, 2'b01);
        step();
        chk("s_exp", ifs.expire, 2'b01);
        chk("s_busy_clr", ifs.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
